fifo_stream_reader: RTL and testbench

- Read-side drainer for the team's synchronous FIFO. Pulls words through the FIFO's read/empty/data_out interface and presents them downstream as a valid/ready stream.
- The FIFO's data_out is registered: data is valid one cycle after read is sampled. The block hides this latency with a 2-entry skid buffer, sustaining 1 word/cycle.
- Sits between the FIFO and any stream consumer.

---
 rtl/fifo_stream_reader_pkg.sv | 5 +
 rtl/fifo_stream_reader_if.sv | 8 +
 rtl/fifo_stream_reader_skid.sv | 36 +++
 rtl/fifo_stream_reader.sv | 47 ++++
 tb/tb_fifo_stream_reader.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// fifo_rd_pkg: shared depth constant and occupancy encoding for the FIFO stream reader.
package fifo_rd_pkg;
  localparam int SKID_DEPTH = 2;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: valid/ready stream carrying one WIDTH-bit word per beat.
interface fifo_stream_reader_if #(parameter int WIDTH = 4);
  logic valid;
  logic ready;
  logic [WIDTH-1:0] data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/fifo_stream_reader_skid.sv
// fifo_skid_buf: 2-entry skid buffer; entry0 is the head presented downstream.
module fifo_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output occ_t             count,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] e0, e1, e0_n, e1_n;
  logic [1:0] cnt_n;
  always_comb begin
    cnt_n = 2'(count) + 2'(push) - 2'(pop);
    // a pop shifts entry1 forward unless a word captured into ONE replaces the head directly
    e0_n = pop ? ((count == TWO || !push) ? e1 : din) : ((push && count == EMPTY) ? din : e0);
    e1_n = (push && (count == TWO ? pop : (count == ONE && !pop))) ? din : e1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count <= EMPTY;
      e0 <= '0;
      e1 <= '0;
    end else if (flush) count <= EMPTY;
    else begin
      count <= occ_t'(cnt_n);
      e0 <= e0_n;
      e1 <= e1_n;
    end
  assign dout = e0;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a registered-output FIFO into a valid/ready stream at 1 word/cycle.
// Define FIFO_RD_COUNT_EN to add the word_cnt delivered-word counter port.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  output logic                    fifo_read,
  input  logic                    fifo_empty,
  input  logic [WIDTH-1:0]        fifo_data,
  fifo_stream_reader_if.master    out
`ifdef FIFO_RD_COUNT_EN
  , output logic [CNT_W-1:0]      word_cnt
`endif
);
  occ_t count;
  logic inflight, pop, room;
  logic [WIDTH-1:0] head;
  assign pop = out.valid && out.ready;
  // room: buffered plus in-flight words, less this cycle's pop, leaves a free slot
  assign room = count == EMPTY ? 1'b1 : count == ONE ? !(inflight && !pop) : (pop && !inflight);
  assign fifo_read = reset && !fifo_empty && !flush && room;
  always_ff @(posedge clk or negedge reset)
    if (!reset) inflight <= 1'b0;
    else inflight <= fifo_read;
  fifo_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .push(inflight && !flush),
    .pop(pop),
    .din(fifo_data),
    .count(count),
    .dout(head)
  );
  assign out.valid = count != EMPTY;
  assign out.data = head;
`ifdef FIFO_RD_COUNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) word_cnt <= '0;
    else if (pop) word_cnt <= word_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: scoreboard bench with a queue-based FIFO model and random stream backpressure.
module tb_fifo_stream_reader;
  localparam int W = 4;
  localparam int CW = 4;
  logic clk = 0, reset = 1, flush = 0, fifo_read, fifo_empty = 1;
  logic [W-1:0] fifo_data = '0;
`ifdef FIFO_RD_COUNT_EN
  logic [CW-1:0] word_cnt;
  int model_cnt = 0;
`endif
  fifo_stream_reader_if #(.WIDTH(W)) s();
  logic [W-1:0] fq[$], exp_q[$];
  int n_chk = 0, n_pass = 0, outstanding = 0, reads = 0, rd_err = 0, occ_err = 0, hold_err = 0;
  logic pv = 0, pr = 0, pf = 0;
  logic [W-1:0] pd = '0;

  fifo_stream_reader #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .fifo_read(fifo_read),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .out(s)
`ifdef FIFO_RD_COUNT_EN
    , .word_cnt(word_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // FIFO with registered data_out: the word read at an edge appears on fifo_data after it
  always @(posedge clk)
    if (reset && fifo_read && !fifo_empty) begin
      fifo_data <= fq.pop_front();
      fifo_empty <= (fq.size() == 0);
    end

  // monitor: sees the handshake values that the next rising edge will act on
  always @(negedge clk)
    if (!reset) pv = 0;
    else begin
      if (fifo_read && fifo_empty) rd_err++;
      if (pv && !pr && !pf && (!s.valid || s.data !== pd)) hold_err++;
      if (s.valid && s.ready) begin
        if (exp_q.size() == 0) chk("sb_pending", exp_q.size(), 1);
        else chk("sb_data", s.data, exp_q.pop_front());
        outstanding--;
`ifdef FIFO_RD_COUNT_EN
        model_cnt = (model_cnt + 1) % (1 << CW);
`endif
      end
      if (fifo_read && !fifo_empty) begin
        outstanding++;
        reads++;
      end
      if (flush) begin
        while (outstanding > 0 && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          outstanding--;
        end
        outstanding = 0;
      end
      if (outstanding > 2) occ_err++;
      pv = s.valid;
      pr = s.ready;
      pf = flush;
      pd = s.data;
    end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_w(input logic [W-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      step();
      t++;
    end
    chk(nm, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 0;
    fq.delete();
    exp_q.delete();
    outstanding = 0;
    fifo_empty = 1;
`ifdef FIFO_RD_COUNT_EN
    model_cnt = 0;
`endif
    #1 chk("arst_valid", s.valid, 0);
`ifdef FIFO_RD_COUNT_EN
    chk("arst_cnt", word_cnt, 0);
`endif
    step();
    step();
    reset = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, np, t;
    s.ready = 0;
    #1 reset = 0;
    #1 chk("rst_valid", s.valid, 0);
    chk("rst_data", s.data, 0);
`ifdef FIFO_RD_COUNT_EN
    chk("rst_cnt", word_cnt, 0);
`endif
    fifo_empty = 0;
    #1 chk("rst_no_read", fifo_read, 0);
    fifo_empty = 1;
    step();
    step();
    reset = 1;
    // burst of 8 with ready held high: 2-cycle latency then one word per cycle
    step();
    s.ready = 1;
    for (int i = 1; i <= 8; i++) push_w(W'(i));
    step();
    chk("t1_lat_valid", s.valid, 0);
    chk("t1_read", fifo_read, 1);
    step();
    chk("t1_first_valid", s.valid, 1);
    chk("t1_first_data", s.data, 1);
    for (int i = 2; i <= 8; i++) begin
      step();
      chk("t1_stream_valid", s.valid, 1);
      chk("t1_stream_data", s.data, i);
    end
    step();
    chk("t1_end_valid", s.valid, 0);
    chk("t1_end_read", fifo_read, 0);
    // backpressure: only two reads may be outstanding
    s.ready = 0;
    r0 = reads;
    push_w(4'h3);
    push_w(4'h4);
    push_w(4'h5);
    repeat (10) step();
    chk("t2_reads", reads - r0, 2);
    chk("t2_hold_valid", s.valid, 1);
    chk("t2_hold_data", s.data, 3);
    chk("t2_fifo_left", fq.size(), 1);
    s.ready = 1;
    for (int k = 3; k <= 5; k++) begin
      chk("t2_burst_valid", s.valid, 1);
      chk("t2_burst_data", s.data, k);
      step();
    end
    chk("t2_end_valid", s.valid, 0);
    // random traffic and backpressure
    np = 0;
    t = 0;
    while (np < 200 && t < 5000) begin
      s.ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        push_w(W'($urandom));
        np++;
      end
      step();
      t++;
    end
    chk("t3_pushed", np, 200);
    s.ready = 1;
    drain("t3_drain");
    // flush with one buffered word and one read in flight; 0xA must survive
    s.ready = 0;
    step();
    push_w(4'hB);
    push_w(4'hC);
    push_w(4'hA);
    step();
    step();
    chk("t4_pre_valid", s.valid, 1);
    flush = 1;
    step();
    chk("t4_flush_valid", s.valid, 0);
    flush = 0;
    s.ready = 1;
    t = 0;
    while (!s.valid && t < 20) begin
      step();
      t++;
    end
    chk("t4_next_data", s.data, 4'hA);
    drain("t4_drain");
    // asynchronous reset mid-stream, then a clean restart
    for (int i = 0; i < 6; i++) push_w(W'(i + 9));
    step();
    step();
    step();
    #1 do_reset();
    for (int i = 1; i <= 4; i++) push_w(W'(i * 3));
    drain("t5_drain");
`ifdef FIFO_RD_COUNT_EN
    chk("cnt_model", word_cnt, model_cnt);
    do_reset();
    for (int i = 0; i < 17; i++) push_w(W'(i));
    drain("t6_drain");
    chk("cnt_wrap", word_cnt, 1);
`endif
    chk("read_while_empty", rd_err, 0);
    chk("occupancy_over_2", occ_err, 0);
    chk("hold_stable", hold_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
